// File: rtl/vlogic_pkg.sv
// Shared opcodes, latency default and ID-pipe entry type for the vector-logic issue arbiter.
// Optional statistics outputs are enabled in the top by defining VLOGIC_ARB_STATS_EN.
package vlogic_pkg;

  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam int unsigned DEF_UNIT_LATENCY = 6;

  // Sized for the largest supported requester count (8).
  localparam int unsigned ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } id_entry_t;

endpackage

// File: rtl/vlogic_rr_pick.sv
// Combinational round-robin picker: first eligible requester searching upward from ptr+1.
module vlogic_rr_pick
  import vlogic_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  int unsigned cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!any && elig[IDX_W'(cand)]) begin
        any                    = 1'b1;
        grant[IDX_W'(cand)]    = 1'b1;
        grant_idx              = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/vlogic_issue_arb.sv
// Round-robin issue arbiter in front of a fixed-latency, non-stalling vector logic unit.
// Define VLOGIC_ARB_STATS_EN to add grant_cnt / busy_cycles statistics outputs.
module vlogic_issue_arb
  import vlogic_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned REQ_DATA_WIDTH = 64,
  parameter int unsigned REQ_ADDR_WIDTH = 32,
  parameter int unsigned OPSEL_WIDTH    = 2,
  parameter int unsigned UNIT_LATENCY   = DEF_UNIT_LATENCY,
  parameter int unsigned MAX_OUT        = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*REQ_DATA_WIDTH-1:0]     req_vec0,
  input  logic [NUM_REQ*REQ_DATA_WIDTH-1:0]     req_vec1,
  input  logic [NUM_REQ*REQ_ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*OPSEL_WIDTH-1:0]        req_opSel,
  input  logic [NUM_REQ-1:0]                    req_sca,
  input  logic [NUM_REQ-1:0]                    req_w_reg,
  output logic                                  unit_in_valid,
  output logic [REQ_DATA_WIDTH-1:0]             unit_in_vec0,
  output logic [REQ_DATA_WIDTH-1:0]             unit_in_vec1,
  output logic [REQ_ADDR_WIDTH-1:0]             unit_in_addr,
  output logic [OPSEL_WIDTH-1:0]                unit_in_opSel,
  output logic                                  unit_in_sca,
  output logic                                  unit_in_w_reg,
  input  logic                                  unit_out_valid,
  input  logic [REQ_DATA_WIDTH-1:0]             unit_out_vec,
  input  logic [REQ_ADDR_WIDTH-1:0]             unit_out_addr,
  input  logic                                  unit_out_sca,
  input  logic                                  unit_out_w_reg,
  output logic [NUM_REQ-1:0]                    resp_valid,
  output logic [REQ_DATA_WIDTH-1:0]             resp_vec,
  output logic [REQ_ADDR_WIDTH-1:0]             resp_addr,
  output logic                                  resp_sca,
  output logic                                  resp_w_reg,
  output logic                                  align_err
`ifdef VLOGIC_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]                 grant_cnt,
  output logic [31:0]                           busy_cycles
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [NUM_REQ-1:0]            elig;
  logic [NUM_REQ-1:0]            grant;
  logic [IDX_W-1:0]              grant_idx;
  logic                          grant_any;

  logic [IDX_W-1:0]              ptr_q, ptr_d;
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  id_entry_t [UNIT_LATENCY:0]    pipe_q, pipe_d;
  id_entry_t                     tail;
  logic                          align_err_q, align_err_d;

  logic                          unit_in_valid_q, unit_in_valid_d;
  logic [REQ_DATA_WIDTH-1:0]     unit_in_vec0_q, unit_in_vec0_d;
  logic [REQ_DATA_WIDTH-1:0]     unit_in_vec1_q, unit_in_vec1_d;
  logic [REQ_ADDR_WIDTH-1:0]     unit_in_addr_q, unit_in_addr_d;
  logic [OPSEL_WIDTH-1:0]        unit_in_opsel_q, unit_in_opsel_d;
  logic                          unit_in_sca_q, unit_in_sca_d;
  logic                          unit_in_w_reg_q, unit_in_w_reg_d;

  // Only the registered count gates eligibility; a same-cycle response frees a slot next cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
    end
  end

  vlogic_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .elig      (elig),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign req_ready = grant;
  assign tail      = pipe_q[UNIT_LATENCY];

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = tail.valid && unit_out_valid && (tail.id == ID_MAX_W'(i));
    end
  end

  assign resp_vec   = unit_out_vec;
  assign resp_addr  = unit_out_addr;
  assign resp_sca   = unit_out_sca;
  assign resp_w_reg = unit_out_w_reg;

  // Next-state: issue register, pointer, ID pipe, counters, alignment flag.
  always_comb begin
    unit_in_valid_d = grant_any;
    unit_in_vec0_d  = '0;
    unit_in_vec1_d  = '0;
    unit_in_addr_d  = '0;
    unit_in_opsel_d = '0;
    unit_in_sca_d   = 1'b0;
    unit_in_w_reg_d = 1'b0;
    ptr_d           = grant_any ? grant_idx : ptr_q;
    pipe_d          = '0;
    cnt_d           = cnt_q;
    align_err_d     = align_err_q | (tail.valid != unit_out_valid);

    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        unit_in_vec0_d  = req_vec0[i*REQ_DATA_WIDTH +: REQ_DATA_WIDTH];
        unit_in_vec1_d  = req_vec1[i*REQ_DATA_WIDTH +: REQ_DATA_WIDTH];
        unit_in_addr_d  = req_addr[i*REQ_ADDR_WIDTH +: REQ_ADDR_WIDTH];
        unit_in_opsel_d = req_opSel[i*OPSEL_WIDTH +: OPSEL_WIDTH];
        unit_in_sca_d   = req_sca[i];
        unit_in_w_reg_d = req_w_reg[i];
      end
    end

    pipe_d[0].valid = grant_any;
    pipe_d[0].id    = ID_MAX_W'(grant_idx);
    for (int k = 1; k <= UNIT_LATENCY; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i] && !resp_valid[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!grant[i] && resp_valid[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q           <= IDX_W'(NUM_REQ - 1);
      cnt_q           <= '0;
      pipe_q          <= '0;
      align_err_q     <= 1'b0;
      unit_in_valid_q <= 1'b0;
      unit_in_vec0_q  <= '0;
      unit_in_vec1_q  <= '0;
      unit_in_addr_q  <= '0;
      unit_in_opsel_q <= '0;
      unit_in_sca_q   <= 1'b0;
      unit_in_w_reg_q <= 1'b0;
    end else begin
      ptr_q           <= ptr_d;
      cnt_q           <= cnt_d;
      pipe_q          <= pipe_d;
      align_err_q     <= align_err_d;
      unit_in_valid_q <= unit_in_valid_d;
      unit_in_vec0_q  <= unit_in_vec0_d;
      unit_in_vec1_q  <= unit_in_vec1_d;
      unit_in_addr_q  <= unit_in_addr_d;
      unit_in_opsel_q <= unit_in_opsel_d;
      unit_in_sca_q   <= unit_in_sca_d;
      unit_in_w_reg_q <= unit_in_w_reg_d;
    end
  end

  assign unit_in_valid = unit_in_valid_q;
  assign unit_in_vec0  = unit_in_vec0_q;
  assign unit_in_vec1  = unit_in_vec1_q;
  assign unit_in_addr  = unit_in_addr_q;
  assign unit_in_opSel = unit_in_opsel_q;
  assign unit_in_sca   = unit_in_sca_q;
  assign unit_in_w_reg = unit_in_w_reg_q;
  assign align_err     = align_err_q;

`ifdef VLOGIC_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]              busy_q, busy_d;

  // Free-running statistics; wrap naturally at 2^32.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    busy_d      = busy_q + 32'(unit_in_valid_q);
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i] + 32'(grant[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      busy_q      <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign grant_cnt   = grant_cnt_q;
  assign busy_cycles = busy_q;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt_chk
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(grant[i] && !resp_valid[i] && (cnt_q[i] >= CNT_W'(MAX_OUT))));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(resp_valid[i] && !grant[i] && (cnt_q[i] == '0)));
  end

endmodule

// File: tb/tb_vlogic_issue_arb.sv
// Randomized scoreboard bench for vlogic_issue_arb with a behavioural 6-cycle logic unit.
module tb_vlogic_issue_arb;
  import vlogic_pkg::*;

  localparam int unsigned N   = 2;
  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 32;
  localparam int unsigned OW  = 2;
  localparam int unsigned LAT = 6;
  localparam int unsigned MO  = 4;
  localparam int unsigned IW  = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_vec0, req_vec1;
  logic [N*AW-1:0]   req_addr;
  logic [N*OW-1:0]   req_opSel;
  logic [N-1:0]      req_sca, req_w_reg;
  logic              unit_in_valid;
  logic [DW-1:0]     unit_in_vec0, unit_in_vec1;
  logic [AW-1:0]     unit_in_addr;
  logic [OW-1:0]     unit_in_opSel;
  logic              unit_in_sca, unit_in_w_reg;
  logic              unit_out_valid;
  logic [DW-1:0]     unit_out_vec;
  logic [AW-1:0]     unit_out_addr;
  logic              unit_out_sca, unit_out_w_reg;
  logic [N-1:0]      resp_valid;
  logic [DW-1:0]     resp_vec;
  logic [AW-1:0]     resp_addr;
  logic              resp_sca, resp_w_reg;
  logic              align_err;
`ifdef VLOGIC_ARB_STATS_EN
  logic [N*32-1:0]   grant_cnt;
  logic [31:0]       busy_cycles;
`endif
  logic              inj_valid;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vlogic_issue_arb #(
    .NUM_REQ(N), .REQ_DATA_WIDTH(DW), .REQ_ADDR_WIDTH(AW),
    .OPSEL_WIDTH(OW), .UNIT_LATENCY(LAT), .MAX_OUT(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vec0(req_vec0), .req_vec1(req_vec1), .req_addr(req_addr),
    .req_opSel(req_opSel), .req_sca(req_sca), .req_w_reg(req_w_reg),
    .unit_in_valid(unit_in_valid), .unit_in_vec0(unit_in_vec0), .unit_in_vec1(unit_in_vec1),
    .unit_in_addr(unit_in_addr), .unit_in_opSel(unit_in_opSel),
    .unit_in_sca(unit_in_sca), .unit_in_w_reg(unit_in_w_reg),
    .unit_out_valid(unit_out_valid), .unit_out_vec(unit_out_vec), .unit_out_addr(unit_out_addr),
    .unit_out_sca(unit_out_sca), .unit_out_w_reg(unit_out_w_reg),
    .resp_valid(resp_valid), .resp_vec(resp_vec), .resp_addr(resp_addr),
    .resp_sca(resp_sca), .resp_w_reg(resp_w_reg),
    .align_err(align_err)
`ifdef VLOGIC_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .busy_cycles(busy_cycles)
`endif
  );

  function automatic logic [DW-1:0] op_result(input logic [OW-1:0] op,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural logic unit: LAT-cycle pipe, cleared by the shared reset.
  logic          u_v [LAT];
  logic [DW-1:0] u_r [LAT];
  logic [AW-1:0] u_a [LAT];
  logic          u_s [LAT];
  logic          u_w [LAT];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        u_v[k] <= 1'b0; u_r[k] <= '0; u_a[k] <= '0; u_s[k] <= 1'b0; u_w[k] <= 1'b0;
      end
    end else begin
      u_v[0] <= unit_in_valid;
      u_r[0] <= op_result(unit_in_opSel, unit_in_vec0, unit_in_vec1);
      u_a[0] <= unit_in_addr;
      u_s[0] <= unit_in_sca;
      u_w[0] <= unit_in_w_reg;
      for (int k = 1; k < LAT; k++) begin
        u_v[k] <= u_v[k-1]; u_r[k] <= u_r[k-1]; u_a[k] <= u_a[k-1];
        u_s[k] <= u_s[k-1]; u_w[k] <= u_w[k-1];
      end
    end
  end

  assign unit_out_valid = u_v[LAT-1] | inj_valid;
  assign unit_out_vec   = u_r[LAT-1];
  assign unit_out_addr  = u_a[LAT-1];
  assign unit_out_sca   = u_s[LAT-1];
  assign unit_out_w_reg = u_w[LAT-1];

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] vec;
    logic [AW-1:0] addr;
    logic          sca;
    logic          w;
  } exp_t;

  exp_t sb[$];
  int   issued  [N];
  int   retired [N];
  int   gcount  [N];
  int   ptr_m;
  logic exp_align;

  // Reference arbiter: rule-level round robin with in-flight = issued - retired.
  initial begin
    ptr_m = N - 1;
    for (int i = 0; i < N; i++) begin issued[i] = 0; gcount[i] = 0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        ptr_m = N - 1;
        for (int i = 0; i < N; i++) begin issued[i] = 0; gcount[i] = 0; end
      end else begin
        int g;
        int c;
        exp_t e;
        logic [N-1:0] exp_ready;
        g = -1;
        for (int k = 1; k <= N; k++) begin
          c = (ptr_m + k) % N;
          if (g < 0 && req_valid[IW'(c)] && (issued[c] - retired[c] < MO)) g = c;
        end
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (g >= 0) begin
          e.due  = cyc + 1 + LAT;
          e.id   = g;
          e.vec  = op_result(req_opSel[g*OW +: OW], req_vec0[g*DW +: DW], req_vec1[g*DW +: DW]);
          e.addr = req_addr[g*AW +: AW];
          e.sca  = req_sca[IW'(g)];
          e.w    = req_w_reg[IW'(g)];
          sb.push_back(e);
          issued[g]++;
          gcount[g]++;
          ptr_m = g;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response is due and checks routing/alignment.
  initial begin
    exp_align = 1'b0;
    for (int i = 0; i < N; i++) retired[i] = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        sb.delete();
        for (int i = 0; i < N; i++) retired[i] = 0;
        exp_align = 1'b0;
      end else begin
        bit   due_now;
        exp_t e;
        chk("align_err", 64'(align_err), 64'(exp_align));
        due_now = (sb.size() > 0) && (sb[0].due == cyc);
        if (inj_valid && !due_now) begin
          chk("resp_valid_on_misalign", 64'(resp_valid), 64'd0);
          exp_align = 1'b1;
        end else if (due_now) begin
          e = sb.pop_front();
          chk("resp_valid", 64'(resp_valid), 64'(N'(1) << e.id));
          chk("resp_vec", resp_vec, e.vec);
          chk("resp_addr", 64'(resp_addr), 64'(e.addr));
          chk("resp_sca", 64'(resp_sca), 64'(e.sca));
          chk("resp_w_reg", 64'(resp_w_reg), 64'(e.w));
          retired[e.id]++;
        end else begin
          chk("resp_valid_idle", 64'(resp_valid), 64'd0);
        end
      end
    end
  end

  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      req_vec0[i*DW +: DW]  = {$urandom, $urandom};
      req_vec1[i*DW +: DW]  = {$urandom, $urandom};
      req_addr[i*AW +: AW]  = $urandom;
      req_opSel[i*OW +: OW] = OW'($urandom_range(1, 3));
    end
    req_sca   = N'($urandom);
    req_w_reg = N'($urandom);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; inj_valid = 1'b0; req_valid = '0;
    req_vec0 = '0; req_vec1 = '0; req_addr = '0; req_opSel = '0; req_sca = '0; req_w_reg = '0;
    step(3);
    rst = 1'b0;
    chk("reset_unit_in_valid", 64'(unit_in_valid), 64'd0);
    chk("reset_align_err", 64'(align_err), 64'd0);
    step(1);

    // Directed AND from requester 0.
    req_vec0[DW-1:0] = 64'hF0F0; req_vec1[DW-1:0] = 64'hFF00;
    req_addr[AW-1:0] = 32'h10;   req_opSel[OW-1:0] = OP_AND;
    req_valid = N'(1);
    step(1);
    req_valid = '0;
    step(10);

    // Both requesters held valid: alternation, then outstanding limit.
    req_valid = '1;
    for (int t = 0; t < 14; t++) begin randomize_fields(); step(1); end
    req_valid = '0;
    step(10);

    // Requester 1 alone against its limit.
    req_valid = N'(2);
    for (int t = 0; t < 12; t++) begin randomize_fields(); step(1); end
    req_valid = '0;
    step(10);

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      randomize_fields();
      req_valid = N'($urandom);
      step(1);
    end
    req_valid = '0;
    step(10);

    // Spurious unit result with an empty pipe.
    inj_valid = 1'b1;
    step(1);
    inj_valid = 1'b0;
    step(4);
    req_valid = '1;
    for (int t = 0; t < 6; t++) begin randomize_fields(); step(1); end
    req_valid = '0;
    step(10);

    // Reset with ops in flight, then requester 0 must win first.
    req_valid = '1;
    for (int t = 0; t < 3; t++) begin randomize_fields(); step(1); end
    req_valid = '0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_unit_in_valid", 64'(unit_in_valid), 64'd0);
    chk("rst_align_err", 64'(align_err), 64'd0);
    req_valid = '1;
    for (int t = 0; t < 8; t++) begin randomize_fields(); step(1); end
    req_valid = '0;
    step(12);

`ifdef VLOGIC_ARB_STATS_EN
    begin
      int total;
      total = 0;
      for (int i = 0; i < N; i++) begin
        chk("grant_cnt", 64'(grant_cnt[i*32 +: 32]), 64'(gcount[i]));
        total += gcount[i];
      end
      chk("busy_cycles", 64'(busy_cycles), 64'(total));
    end
`endif

    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
